// File: rtl/mlp_controller.sv
// Purpose: sequences three hidden-layer passes and one output-layer pass per inference for the MLP datapath.
// Latency: done pulses 4*(settle_cycles+1)+1 cycles after the cycle in which start is sampled.
// Backpressure: start is sampled only in IDLE; a start seen while busy is dropped, not queued.
module mlp_controller #(
  parameter int input_size                 = 10,
  parameter int size_of_hidden_layer       = 30,  // must be 3*input_size: curr_layer encodes 3 hidden groups + output
  parameter int clog2_size_of_output_layer = 4,
  parameter int settle_cycles              = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [clog2_size_of_output_layer-1:0] label_in,
  output logic [1:0]                            curr_layer,
  output logic [size_of_hidden_layer-1:0]       ld_en,
  output logic                                  busy,
  output logic                                  done,
  output logic [clog2_size_of_output_layer-1:0] label_out,
  output logic                                  label_valid
);

  // Settle counter must hold 0..settle_cycles; keep at least one bit when settle_cycles is 0.
  localparam int CW = (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
  localparam logic [CW-1:0] C_LAST = CW'(settle_cycles);
  localparam logic [size_of_hidden_layer-1:0] GRP0 =
    {{(size_of_hidden_layer-input_size){1'b0}}, {input_size{1'b1}}};
  localparam logic [1:0] P_OUT = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_PASS, S_DONE} state_t;

  state_t                                r_state, w_state_nxt;
  logic [1:0]                            r_p, w_p_nxt;
  logic [CW-1:0]                         r_c, w_c_nxt;
  logic [clog2_size_of_output_layer-1:0] r_label, w_label_nxt;
  logic                                  r_valid, w_valid_nxt;
  logic                                  w_action;

  // The last cycle of each pass is where the group load or label capture happens.
  assign w_action = (r_state == S_PASS) && (r_c == C_LAST);

  // State and result registers; reset aborts any inference in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_p     <= 2'd0;
      r_c     <= '0;
      r_label <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_p     <= w_p_nxt;
      r_c     <= w_c_nxt;
      r_label <= w_label_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic: walk passes 0..3, capture label at the end of the output pass.
  always_comb begin
    w_state_nxt = r_state;
    w_p_nxt     = r_p;
    w_c_nxt     = r_c;
    w_label_nxt = r_label;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PASS;
          w_p_nxt     = 2'd0;
          w_c_nxt     = '0;
          w_valid_nxt = 1'b0;
        end
      end
      S_PASS: begin
        if (!w_action) begin
          w_c_nxt = r_c + CW'(1);
        end else if (r_p != P_OUT) begin
          w_p_nxt = r_p + 2'd1;
          w_c_nxt = '0;
        end else begin
          w_label_nxt = label_in;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from registered state only; label_in never reaches an output combinationally.
  always_comb begin
    curr_layer = 2'd0;
    ld_en      = '0;
    case (r_state)
      S_PASS:  curr_layer = r_p;
      S_DONE:  curr_layer = P_OUT;
      default: curr_layer = 2'd0;
    endcase
    if (w_action) begin
      case (r_p)
        2'd0:    ld_en = GRP0;
        2'd1:    ld_en = GRP0 << input_size;
        2'd2:    ld_en = GRP0 << (2 * input_size);
        default: ld_en = '0;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign label_out   = r_label;
  assign label_valid = r_valid;

endmodule

// File: doc/mlp_controller.md
Name: mlp_controller

Overview:
- Sequencer for the MLP datapath: drives curr_layer and ld_en through three hidden-layer passes and one output-layer pass per inference.
- The datapath has input_size (10) shared PUs. Each pass computes one group of neurons. Each hidden group is latched into the datapath's hidden-result registers.
- At the end of the output pass, the datapath's combinational label is captured and reported with a start/done handshake.
- Sits between the top-level testbench/host and the datapath.

Parameters:
input_size, 10, number of parallel PUs (neurons computed per pass)
size_of_hidden_layer, 30, hidden neurons; must equal 3*input_size (2-bit layer encoding)
clog2_size_of_output_layer, 4, width of label
settle_cycles, 1, extra wait cycles per pass before the load/capture cycle, for PU settling (0 allowed)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
start  input  1  request an inference; sampled only in IDLE
label_in  input  clog2_size_of_output_layer  combinational label from datapath LabelFinder
curr_layer  output  2  layer/group select to datapath: 0,1,2 = hidden groups, 3 = output layer
ld_en  output  size_of_hidden_layer  per-neuron hidden-result load enables
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when label_out becomes valid
label_out  output  clog2_size_of_output_layer  registered inference result
label_valid  output  1  label_out holds the result of the last completed inference

Behaviour:
- Reset:
  - rst low asynchronously forces state to IDLE and clears all registers.
  - Outputs under reset: curr_layer=0, ld_en=0, busy=0, done=0, label_out=0, label_valid=0.
  - Reset mid-inference aborts the inference. No partial ld_en or label update occurs after rst is asserted.
- All outputs are decoded from registered state only. There is no combinational path from start or label_in to any output.
- States: IDLE, PASS, DONE. PASS carries a 2-bit pass index p (0..3) and a settle counter c (0..settle_cycles).
- IDLE:
  - curr_layer=0, ld_en=0.
  - If start=1 at a rising edge: go to PASS with p=0, c=0, and clear label_valid.
  - start=0: stay in IDLE.
- PASS:
  - curr_layer=p.
  - Each pass lasts settle_cycles+1 cycles. The final cycle is the one where c==settle_cycles (the action cycle).
  - Non-action cycles: ld_en=0, c increments.
  - Action cycle, p<3: ld_en bits [p*input_size +: input_size] are all 1, all other bits 0. Next state is PASS with p+1, c=0.
  - Action cycle, p=3: ld_en=0. label_in is registered into label_out at the closing edge. Next state is DONE.
- DONE:
  - Lasts one cycle. done=1, label_valid=1, busy=1, curr_layer=3 (held), ld_en=0.
  - Next state is IDLE unconditionally.
- Latency:
  - Let the start-sampling cycle be cycle 0. Pass p occupies cycles p*(S+1)+1 .. (p+1)*(S+1), where S=settle_cycles.
  - done is high in cycle 4*(S+1)+1, i.e. 9 for the default S=1.
  - The earliest next start is accepted in cycle 4*(S+1)+2.
- start while busy (PASS or DONE): ignored, not queued.
- label_valid stays high in IDLE after completion. It clears on the next accepted start. label_out holds its value until the next capture or reset.
- ld_en is never asserted for more than one group in any cycle, and never outside a PASS action cycle with p<3.

Test Plan:
- Reset: hold rst=0 with start=1 -> all outputs 0. Release rst with start=0 -> remains IDLE, busy=0.
- Single inference, S=1, start pulsed in cycle 0:
  - curr_layer = 0,0,1,1,2,2,3,3 in cycles 1-8.
  - ld_en = 0x3FF in cycle 2, 0xFFC00 in cycle 4, 0x3FF00000 in cycle 6, 0 in all other cycles.
  - label_in=7 in cycle 8 -> label_out=7, done=1, label_valid=1 in cycle 9.
  - busy=1 in cycles 1-9, busy=0 in cycle 10.
- Start held high continuously (S=1) -> inferences start in cycles 0, 10, 20. label_valid drops in cycle 11 and rises in cycle 19. The extra start pulses during busy have no effect.
- Reset mid-inference: rst=0 asynchronously in cycle 5 (between edges) -> outputs 0 immediately. The 0x3FF00000 load never appears, done never pulses, label_valid=0.
- Parameter S=0: start in cycle 0 -> ld_en group loads in cycles 1, 2, 3, label capture in cycle 4, done in cycle 5.
- Back-to-back label retention: complete an inference with label 3, idle 20 cycles -> label_out=3 and label_valid=1 throughout. The next start clears label_valid in cycle 1.
